// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    RD_I,
    WT_I,
    CALC_J,
    RD_J,
    WT_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } rc4_state_t;

  // Number of S-box entries for a given address width.
  function automatic int rc4_entries(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rc4_mod_counter.sv
// Wrapping modulo-MOD counter with synchronous clear and enable.
module rc4_mod_counter #(
  parameter int MOD = 3,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill, then the KSA swap loop
// against a single-port synchronous S-box RAM with configurable read latency.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1,
  parameter int INIT_EN   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [KEY_BYTES*ADDR_W-1:0] key,
  input  logic                        start,
  input  logic                        done_ack,
  input  logic [ADDR_W-1:0]           q,
  output logic [ADDR_W-1:0]           addr,
  output logic [ADDR_W-1:0]           data,
  output logic                        wren,
  output logic                        busy,
  output logic                        done
);

  localparam int N  = rc4_entries(ADDR_W);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     WT_LAST  = CW'(RD_LAT - 1);

  rc4_state_t state, state_nx;

  logic [ADDR_W-1:0] i, i_nx;
  logic [ADDR_W-1:0] j, j_nx;
  logic [ADDR_W-1:0] si;
  logic [ADDR_W-1:0] jn;
  logic [ADDR_W-1:0] kb;
  logic [ADDR_W-1:0] key_a [KEY_BYTES];
  logic [ADDR_W-1:0] addr_nx, data_nx;
  logic              wren_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [KW-1:0]     k;
  logic              k_clr, k_en, key_ld;

  rc4_mod_counter #(
    .MOD (KEY_BYTES),
    .W   (KW)
  ) u_kidx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (k_clr),
    .en    (k_en),
    .cnt   (k)
  );

  // Key element 0 sits in the most-significant bits of the key bus.
  always_ff @(posedge clk) begin
    if (key_ld) begin
      for (int e = 0; e < KEY_BYTES; e++) begin
        key_a[e] <= key[(KEY_BYTES-1-e)*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    kb = '0;
    for (int e = 0; e < KEY_BYTES; e++) begin
      if (k == KW'(e)) kb = key_a[e];
    end
  end

  assign jn = j + q + kb;

  always_ff @(posedge clk) begin
    if (state == CALC_J) si <= q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      cnt   <= '0;
      addr  <= '0;
      data  <= '0;
      wren  <= 1'b0;
    end else begin
      state <= state_nx;
      i     <= i_nx;
      j     <= j_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
      data  <= data_nx;
      wren  <= wren_nx;
    end
  end

  always_comb begin
    state_nx = state;
    i_nx     = i;
    j_nx     = j;
    cnt_nx   = cnt;
    k_clr    = 1'b0;
    k_en     = 1'b0;
    key_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_ld   = 1'b1;
          k_clr    = 1'b1;
          i_nx     = '0;
          j_nx     = '0;
          state_nx = (INIT_EN != 0) ? FILL : RD_I;
        end
      end
      // i doubles as the fill address and wraps back to 0 for the shuffle.
      FILL: begin
        i_nx = i + 1'b1;
        if (i == LAST_IDX) state_nx = RD_I;
      end
      RD_I: begin
        cnt_nx   = '0;
        state_nx = WT_I;
      end
      WT_I: begin
        if (cnt == WT_LAST) state_nx = CALC_J;
        else                cnt_nx   = cnt + 1'b1;
      end
      CALC_J: begin
        j_nx     = jn;
        state_nx = (jn == i) ? NEXT : RD_J;
      end
      RD_J: begin
        cnt_nx   = '0;
        state_nx = WT_J;
      end
      WT_J: begin
        if (cnt == WT_LAST) state_nx = WR_I;
        else                cnt_nx   = cnt + 1'b1;
      end
      WR_I: state_nx = WR_J;
      WR_J: state_nx = NEXT;
      NEXT: begin
        if (i == LAST_IDX) begin
          state_nx = DONE;
        end else begin
          i_nx     = i + 1'b1;
          k_en     = 1'b1;
          state_nx = RD_I;
        end
      end
      DONE: begin
        if (done_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // RAM controls are decoded from the upcoming state so they are registered
  // and hold steady for the full cycle of that state; s[j] is captured into
  // data on the edge that enters WR_I.
  always_comb begin
    addr_nx = '0;
    data_nx = '0;
    wren_nx = 1'b0;
    case (state_nx)
      FILL: begin
        addr_nx = i_nx;
        data_nx = i_nx;
        wren_nx = 1'b1;
      end
      RD_I, WT_I, CALC_J: addr_nx = i_nx;
      RD_J, WT_J:         addr_nx = j_nx;
      WR_I: begin
        addr_nx = i_nx;
        data_nx = q;
        wren_nx = 1'b1;
      end
      WR_J: begin
        addr_nx = j_nx;
        data_nx = si;
        wren_nx = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: three configurations, each with its own RAM model.
module tb_rc4_ksa_engine;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  logic [23:0] key_a, key_b;
  logic [3:0]  key_c;
  logic        start_a, start_b, start_c;
  logic        ack_a, ack_b, ack_c;
  logic [7:0]  q_a, q_b, addr_a, addr_b, data_a, data_b;
  logic [3:0]  q_c, addr_c, data_c;
  logic        wren_a, wren_b, wren_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ld_c;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [3:0] mem_c [16];
  logic [7:0] pa;
  logic [7:0] pb [3];
  logic [3:0] pc [2];

  int   sel;
  logic [7:0] c_addr, c_data;
  logic       c_wren, c_busy, c_done;

  int exp_s [256];
  int wr_a [$];
  int wr_d [$];
  int wr_c [$];

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(1), .INIT_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .key(key_a), .start(start_a), .done_ack(ack_a), .q(q_a),
    .addr(addr_a), .data(data_a), .wren(wren_a), .busy(busy_a), .done(done_a));

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(3), .INIT_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .key(key_b), .start(start_b), .done_ack(ack_b), .q(q_b),
    .addr(addr_b), .data(data_b), .wren(wren_b), .busy(busy_b), .done(done_b));

  rc4_ksa_engine #(.ADDR_W(4), .KEY_BYTES(1), .RD_LAT(2), .INIT_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .key(key_c), .start(start_c), .done_ack(ack_c), .q(q_c),
    .addr(addr_c), .data(data_c), .wren(wren_c), .busy(busy_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs with read latency matching each instance
  always @(posedge clk) begin
    if (wren_a) mem_a[addr_a] <= data_a;
    pa <= mem_a[addr_a];
  end
  assign q_a = pa;

  always @(posedge clk) begin
    if (wren_b) mem_b[addr_b] <= data_b;
    pb[0] <= mem_b[addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign q_b = pb[2];

  always @(posedge clk) begin
    if (ld_c) begin
      for (int x = 0; x < 16; x++) mem_c[x] <= 4'(x);
    end else if (wren_c) begin
      mem_c[addr_c] <= data_c;
    end
    pc[0] <= mem_c[addr_c];
    pc[1] <= pc[0];
  end
  assign q_c = pc[1];

  always_comb begin
    c_addr = addr_a; c_data = data_a; c_wren = wren_a; c_busy = busy_a; c_done = done_a;
    case (sel)
      1: begin
        c_addr = addr_b; c_data = data_b; c_wren = wren_b; c_busy = busy_b; c_done = done_b;
      end
      2: begin
        c_addr = {4'b0, addr_c}; c_data = {4'b0, data_c};
        c_wren = wren_c; c_busy = busy_c; c_done = done_c;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference KSA from the identity permutation; also returns start-to-done cycles.
  task automatic ksa_model(input int n, input int kl, input int w, input logic [23:0] key,
                           input int lat, input int init, output int cyc);
    int kel [16];
    int j, t, cost;
    for (int e = 0; e < kl; e++) kel[e] = int'(key >> ((kl - 1 - e) * w)) & (n - 1);
    for (int x = 0; x < n; x++) exp_s[x] = x;
    j = 0;
    cost = 0;
    for (int i = 0; i < n; i++) begin
      j = (j + exp_s[i] + kel[i % kl]) % n;
      if (j == i) cost += 3 + lat;
      else        cost += 6 + 2 * lat;
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
    end
    cyc = 1 + init * n + cost;
  endtask

  task automatic cmp_mem(input string tag, input int n);
    int bad;
    bad = 0;
    for (int x = 0; x < n; x++) begin
      case (sel)
        0:       if (32'(mem_a[x]) != 32'(exp_s[x])) bad++;
        1:       if (32'(mem_b[x]) != 32'(exp_s[x])) bad++;
        default: if (32'(mem_c[x]) != 32'(exp_s[x])) bad++;
      endcase
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic start_run(input int s, input logic [23:0] k);
    sel = s;
    case (s)
      0:       begin key_a = k;      start_a = 1'b1; end
      1:       begin key_b = k;      start_b = 1'b1; end
      default: begin key_c = k[3:0]; start_c = 1'b1; end
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Current negedge is cycle 1 after the start edge; returns the cycle done is first seen.
  task automatic wait_done(output int cyc, output logic b1);
    cyc = 1;
    b1  = c_busy;
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    while (c_done !== 1'b1 && cyc < 8000) begin
      if (c_wren) begin
        wr_a.push_back(32'(c_addr));
        wr_d.push_back(32'(c_data));
        wr_c.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic ack();
    ack_a = 1'b1; ack_b = 1'b1; ack_c = 1'b1;
    @(negedge clk);
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    check("ack_done_low", 32'(c_done), 32'd0);
  endtask

  initial begin
    int   cyc, lat, bad, cnt;
    logic b1;
    n_chk = 0; n_err = 0; sel = 0; ld_c = 1'b0;
    rst_n = 1'b0;
    key_a = '0; key_b = '0; key_c = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_wren", 32'(wren_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy_a), 32'd0);

    // Identity fill then first swap (j = 1)
    start_run(0, 24'h010203);
    wait_done(cyc, b1);
    ksa_model(256, 3, 8, 24'h010203, 1, 1, lat);
    check("t1_busy_rise", 32'(b1), 32'd1);
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (wr_a[x] != x || wr_d[x] != x || wr_c[x] != x + 1) bad++;
    check("t1_fill", 32'(bad), 32'd0);
    check("t1_wri_addr", 32'(wr_a[256]), 32'd0);
    check("t1_wri_data", 32'(wr_d[256]), 32'd1);
    check("t1_wrj_addr", 32'(wr_a[257]), 32'd1);
    check("t1_wrj_data", 32'(wr_d[257]), 32'd0);
    check("t1_latency", 32'(cyc), 32'(lat));
    cmp_mem("t1_ram", 256);
    ack();

    // Zero key: i=0 and i=1 skip, first writes at i=2 in cycle 270
    start_run(0, 24'h000000);
    wait_done(cyc, b1);
    ksa_model(256, 3, 8, 24'h000000, 1, 1, lat);
    check("t2_first_wr_cyc", 32'(wr_c[256]), 32'd270);
    check("t2_wri_addr", 32'(wr_a[256]), 32'd2);
    check("t2_wri_data", 32'(wr_d[256]), 32'd3);
    check("t2_wrj_addr", 32'(wr_a[257]), 32'd3);
    check("t2_wrj_data", 32'(wr_d[257]), 32'd2);
    check("t2_latency", 32'(cyc), 32'(lat));
    cmp_mem("t2_ram", 256);
    ack();

    // Full run, RD_LAT=1, then DONE hold and start+done_ack together
    start_run(0, 24'h000249);
    wait_done(cyc, b1);
    ksa_model(256, 3, 8, 24'h000249, 1, 1, lat);
    check("t3_latency", 32'(cyc), 32'(lat));
    cmp_mem("t3_ram", 256);
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_done_hold", 32'(c_done), 32'd1);
    check("t3_done_busy", 32'(c_busy), 32'd0);
    ack_a = 1'b1;
    @(negedge clk);
    check("t3_corner_done", 32'(c_done), 32'd0);
    check("t3_corner_busy", 32'(c_busy), 32'd0);
    @(negedge clk);
    start_a = 1'b0;
    ack_a = 1'b0;
    wait_done(cyc, b1);
    check("t3_restart_busy", 32'(b1), 32'd1);
    check("t3_restart_lat", 32'(cyc), 32'(lat));
    cmp_mem("t3_restart_ram", 256);
    ack();

    // RD_LAT=3 with the key bus changed right after the start edge
    start_run(1, 24'h000249);
    key_b = 24'hffffff;
    wait_done(cyc, b1);
    ksa_model(256, 3, 8, 24'h000249, 3, 1, lat);
    check("t4_latency", 32'(cyc), 32'(lat));
    cmp_mem("t4_ram", 256);
    ack();
    @(negedge clk);
    check("t4_stay_idle", 32'(c_busy), 32'd0);

    // 16-entry, single key element, no fill, identity preload
    ld_c = 1'b1;
    @(negedge clk);
    ld_c = 1'b0;
    start_run(2, 24'h000005);
    wait_done(cyc, b1);
    ksa_model(16, 1, 4, 24'h000005, 2, 0, lat);
    check("t5_latency", 32'(cyc), 32'(lat));
    cmp_mem("t5_ram", 16);
    ack();

    // Asynchronous reset during the first WR_I (writes mem[0]=1)
    start_run(0, 24'h010203);
    cnt = 0;
    while (!(c_wren && c_addr == 8'd0 && c_data == 8'd1) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_reached_wri", 32'(c_wren), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_addr", 32'(addr_a), 32'd0);
    check("t6_rst_data", 32'(data_a), 32'd0);
    check("t6_rst_wren", 32'(wren_a), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_busy", 32'(busy_a), 32'd0);
    start_run(0, 24'h000249);
    wait_done(cyc, b1);
    ksa_model(256, 3, 8, 24'h000249, 1, 1, lat);
    check("t6_latency", 32'(cyc), 32'(lat));
    cmp_mem("t6_ram", 256);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
